// File: rtl/ex_unit.sv
// ex_unit -- single-issue execute unit with a result register and branch squash.
//
// Executes ADD/SUB/AND/OR/XOR in a single cycle. SHL/SHR shift one bit per
// cycle. BR computes a PC-relative target and checks the condition code against
// the flag register. A taken branch squashes the next accepted instruction.
// Optional feature macro: EX_UNIT_MUL_EN makes op 8 an iterative shift-add
// multiply. Without it, op 8 is a NOP and no multiplier logic exists.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   v_i, stall_i    instruction valid in, downstream not ready
//   stall_o         unit cannot accept an instruction this cycle
//   op_i, immf_i, wb_i, rd_addr_i, cc_i
//                   opcode, immediate select, writeback, destination, branch cc
//   rd_value_i, rs_value_i, imm_value_i, pc_value_i
//                   operand A, operand B, immediate operand B, instruction PC
//   v_o, wb_en_o, rd_addr_o, result_o, branch_en_o, flags_o
//                   registered result; flags are {Z,P,N,V}
module ex_unit #(
  parameter int XLEN = 32,
  parameter int PC_W = 16,
  parameter int RA_W = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            v_i,
  input  logic            stall_i,
  output logic            stall_o,
  input  logic [3:0]      op_i,
  input  logic            immf_i,
  input  logic            wb_i,
  input  logic [RA_W-1:0] rd_addr_i,
  input  logic [2:0]      cc_i,
  input  logic [XLEN-1:0] rd_value_i,
  input  logic [XLEN-1:0] rs_value_i,
  input  logic [XLEN-1:0] imm_value_i,
  input  logic [PC_W-1:0] pc_value_i,
  output logic            v_o,
  output logic            wb_en_o,
  output logic [RA_W-1:0] rd_addr_o,
  output logic [XLEN-1:0] result_o,
  output logic            branch_en_o,
  output logic [3:0]      flags_o
);

  localparam int SH_W  = $clog2(XLEN);
  localparam int CNT_W = SH_W + 1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1'b1);

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4;
  localparam logic [3:0] OP_SHL = 4'd5;
  localparam logic [3:0] OP_SHR = 4'd6;
  localparam logic [3:0] OP_BR  = 4'd7;
`ifdef EX_UNIT_MUL_EN
  localparam logic [3:0] OP_MUL = 4'd8;
`endif

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_ITER = 2'd1, S_HOLD = 2'd2} state_e;
  typedef enum logic [1:0] {K_NOP = 2'd0, K_ALU = 2'd1, K_MULTI = 2'd2, K_BR = 2'd3} kind_e;

  // Flag vector {Z,P,N,V} for a result with the given overflow bit.
  function automatic logic [3:0] calc_flags(input logic [XLEN-1:0] r, input logic ovf);
    logic z;
    logic n;
    z = (r == {XLEN{1'b0}});
    n = r[XLEN-1];
    return {z, ~z & ~n, n, ovf};
  endfunction

  state_e            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [3:0]        it_op_q;
  logic [XLEN-1:0]   sh_q;
  logic [RA_W-1:0]   it_rd_q;
  logic              it_wb_q;
  logic              squash_q;
  logic              v_q;
  logic              wb_q;
  logic              br_q;
  logic [RA_W-1:0]   rd_q;
  logic [XLEN-1:0]   res_q;
  logic [3:0]        flags_q;
`ifdef EX_UNIT_MUL_EN
  logic [XLEN-1:0]   acc_q;
  logic [XLEN-1:0]   mb_q;
  logic [XLEN-1:0]   acc_d;
`endif

  logic [XLEN-1:0]   opb_d;
  logic [SH_W-1:0]   shamt_d;
  logic              accept_d;
  kind_e             kind_d;
  logic [XLEN-1:0]   alu_res_d;
  logic              alu_v_d;
  logic              taken_d;
  logic [PC_W-1:0]   opb_pc_d;
  logic [PC_W-1:0]   tgt_d;
  logic [XLEN-1:0]   br_res_d;
  logic [CNT_W-1:0]  cnt_init_d;
  logic [XLEN-1:0]   sh_d;
  logic [XLEN-1:0]   it_res_d;

  assign opb_d   = immf_i ? imm_value_i : rs_value_i;
  assign shamt_d = opb_d[SH_W-1:0];

  // The ITER term keeps v_i waiting during a multicycle op; reset forces accept-ready low.
  assign stall_o  = ~rst & ((state_q == S_ITER) | (v_q & stall_i));
  assign accept_d = v_i & ~stall_o & ~rst;

  assign v_o         = v_q;
  assign wb_en_o     = wb_q;
  assign rd_addr_o   = rd_q;
  assign result_o    = res_q;
  assign branch_en_o = br_q;
  assign flags_o     = flags_q;

  // Branch target arithmetic is PC_W wide; B is truncated or zero-extended to fit.
  if (XLEN >= PC_W) begin : g_opb_trunc
    assign opb_pc_d = opb_d[PC_W-1:0];
  end else begin : g_opb_ext
    assign opb_pc_d = {{(PC_W-XLEN){1'b0}}, opb_d};
  end
  assign tgt_d = pc_value_i + opb_pc_d;
  if (XLEN >= PC_W) begin : g_tgt_ext
    assign br_res_d = {{(XLEN-PC_W){1'b0}}, tgt_d};
  end else begin : g_tgt_trunc
    assign br_res_d = tgt_d[XLEN-1:0];
  end

  // Decode the incoming op into a class and compute the single-cycle ALU result.
  always_comb begin
    kind_d    = K_NOP;
    alu_res_d = {XLEN{1'b0}};
    alu_v_d   = 1'b0;
    case (op_i)
      OP_ADD: begin
        kind_d    = K_ALU;
        alu_res_d = rd_value_i + opb_d;
        alu_v_d   = (rd_value_i[XLEN-1] == opb_d[XLEN-1]) &
                    (alu_res_d[XLEN-1] != rd_value_i[XLEN-1]);
      end
      OP_SUB: begin
        kind_d    = K_ALU;
        alu_res_d = rd_value_i - opb_d;
        alu_v_d   = (rd_value_i[XLEN-1] != opb_d[XLEN-1]) &
                    (alu_res_d[XLEN-1] != rd_value_i[XLEN-1]);
      end
      OP_AND: begin
        kind_d    = K_ALU;
        alu_res_d = rd_value_i & opb_d;
      end
      OP_OR: begin
        kind_d    = K_ALU;
        alu_res_d = rd_value_i | opb_d;
      end
      OP_XOR: begin
        kind_d    = K_ALU;
        alu_res_d = rd_value_i ^ opb_d;
      end
      OP_SHL, OP_SHR: begin
        // A zero shift amount completes immediately with A unchanged.
        alu_res_d = rd_value_i;
        if (shamt_d == {SH_W{1'b0}}) begin
          kind_d = K_ALU;
        end else begin
          kind_d = K_MULTI;
        end
      end
      OP_BR: begin
        kind_d = K_BR;
      end
`ifdef EX_UNIT_MUL_EN
      OP_MUL: begin
        kind_d = K_MULTI;
      end
`endif
      default: begin
        kind_d = K_NOP;
      end
    endcase
  end

  // Branch condition against the current flag register {Z,P,N,V}.
  always_comb begin
    taken_d = 1'b0;
    case (cc_i)
      3'd0:    taken_d = 1'b1;
      3'd1:    taken_d = flags_q[3];
      3'd2:    taken_d = ~flags_q[3];
      3'd3:    taken_d = flags_q[1];
      3'd4:    taken_d = flags_q[2];
      3'd5:    taken_d = flags_q[0];
      3'd6:    taken_d = flags_q[1] | flags_q[3];
      default: taken_d = 1'b0;
    endcase
  end

  // Iteration count at entry to ITER: the shift amount, or XLEN for a multiply.
  always_comb begin
    cnt_init_d = {1'b0, shamt_d};
`ifdef EX_UNIT_MUL_EN
    if (op_i == OP_MUL) begin
      cnt_init_d = CNT_W'(XLEN);
    end else begin
      cnt_init_d = {1'b0, shamt_d};
    end
`endif
  end

  // One ITER step: shift sh_q by one bit (left for SHL and MUL, right for SHR).
  always_comb begin
    sh_d = {sh_q[XLEN-2:0], 1'b0};
    if (it_op_q == OP_SHR) begin
      sh_d = {1'b0, sh_q[XLEN-1:1]};
    end else begin
      sh_d = {sh_q[XLEN-2:0], 1'b0};
    end
`ifdef EX_UNIT_MUL_EN
    // Shift-add: sh_q holds A<<k, and mb_q[0] holds bit k of B.
    acc_d = acc_q + (mb_q[0] ? sh_q : {XLEN{1'b0}});
    if (it_op_q == OP_MUL) begin
      it_res_d = acc_d;
    end else begin
      it_res_d = sh_d;
    end
`else
    it_res_d = sh_d;
`endif
  end

  // Control FSM and output register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= {CNT_W{1'b0}};
      it_op_q  <= 4'd0;
      sh_q     <= {XLEN{1'b0}};
      it_rd_q  <= {RA_W{1'b0}};
      it_wb_q  <= 1'b0;
      squash_q <= 1'b0;
      v_q      <= 1'b0;
      wb_q     <= 1'b0;
      br_q     <= 1'b0;
      rd_q     <= {RA_W{1'b0}};
      res_q    <= {XLEN{1'b0}};
      flags_q  <= 4'd0;
`ifdef EX_UNIT_MUL_EN
      acc_q    <= {XLEN{1'b0}};
      mb_q     <= {XLEN{1'b0}};
`endif
    end else begin
      case (state_q)
        S_ITER: begin
          cnt_q <= cnt_q - CNT_ONE;
          sh_q  <= sh_d;
`ifdef EX_UNIT_MUL_EN
          acc_q <= acc_d;
          mb_q  <= {1'b0, mb_q[XLEN-1:1]};
`endif
          if (cnt_q == CNT_ONE) begin
            state_q <= S_IDLE;
            v_q     <= 1'b1;
            wb_q    <= it_wb_q;
            br_q    <= 1'b0;
            rd_q    <= it_rd_q;
            res_q   <= it_res_d;
            flags_q <= calc_flags(it_res_d, 1'b0);
          end else begin
            state_q <= S_ITER;
          end
        end
        S_IDLE, S_HOLD: begin
          if (v_q && stall_i) begin
            state_q <= S_HOLD;
          end else begin
            state_q <= S_IDLE;
            v_q     <= 1'b0;
            wb_q    <= 1'b0;
            br_q    <= 1'b0;
            if (accept_d) begin
              if (squash_q) begin
                // Shadow of a taken branch: consume the instruction with no effect.
                squash_q <= 1'b0;
              end else begin
                case (kind_d)
                  K_ALU: begin
                    v_q     <= 1'b1;
                    wb_q    <= wb_i;
                    rd_q    <= rd_addr_i;
                    res_q   <= alu_res_d;
                    flags_q <= calc_flags(alu_res_d, alu_v_d);
                  end
                  K_MULTI: begin
                    state_q <= S_ITER;
                    cnt_q   <= cnt_init_d;
                    sh_q    <= rd_value_i;
                    it_op_q <= op_i;
                    it_rd_q <= rd_addr_i;
                    it_wb_q <= wb_i;
`ifdef EX_UNIT_MUL_EN
                    acc_q   <= {XLEN{1'b0}};
                    mb_q    <= opb_d;
`endif
                  end
                  K_BR: begin
                    v_q      <= 1'b1;
                    br_q     <= taken_d;
                    rd_q     <= rd_addr_i;
                    res_q    <= br_res_d;
                    squash_q <= taken_d;
                  end
                  default: begin
                    v_q  <= 1'b1;
                    rd_q <= rd_addr_i;
                  end
                endcase
              end
            end else begin
              squash_q <= squash_q;
            end
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ex_unit.sv
module tb_ex_unit;
  localparam int XLEN = 32;
  localparam int PC_W = 16;
  localparam int RA_W = 4;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4;
  localparam logic [3:0] OP_SHL = 4'd5;
  localparam logic [3:0] OP_SHR = 4'd6;
  localparam logic [3:0] OP_BR  = 4'd7;
  localparam logic [3:0] OP_8   = 4'd8;
  localparam logic [3:0] OP_12  = 4'd12;

  logic            clk;
  logic            rst;
  logic            v_i;
  logic            stall_i;
  logic            stall_o;
  logic [3:0]      op_i;
  logic            immf_i;
  logic            wb_i;
  logic [RA_W-1:0] rd_addr_i;
  logic [2:0]      cc_i;
  logic [XLEN-1:0] rd_value_i;
  logic [XLEN-1:0] rs_value_i;
  logic [XLEN-1:0] imm_value_i;
  logic [PC_W-1:0] pc_value_i;
  logic            v_o;
  logic            wb_en_o;
  logic [RA_W-1:0] rd_addr_o;
  logic [XLEN-1:0] result_o;
  logic            branch_en_o;
  logic [3:0]      flags_o;

  ex_unit #(.XLEN(XLEN), .PC_W(PC_W), .RA_W(RA_W)) dut (
    .clk(clk), .rst(rst), .v_i(v_i), .stall_i(stall_i), .stall_o(stall_o),
    .op_i(op_i), .immf_i(immf_i), .wb_i(wb_i), .rd_addr_i(rd_addr_i), .cc_i(cc_i),
    .rd_value_i(rd_value_i), .rs_value_i(rs_value_i), .imm_value_i(imm_value_i),
    .pc_value_i(pc_value_i), .v_o(v_o), .wb_en_o(wb_en_o), .rd_addr_o(rd_addr_o),
    .result_o(result_o), .branch_en_o(branch_en_o), .flags_o(flags_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] res;
    logic [3:0]  flags;
    logic        wb;
    logic [3:0]  rd;
    logic        br;
    bit          chk_res;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // Monitor: a result is consumed on a cycle where v_o=1 and downstream is ready.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (rst === 1'b0 && v_o === 1'b1 && stall_i === 1'b0) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_result: got result=%h flags=%b with no expectation queued",
                   result_o, flags_o);
        end else begin
          e = exp_q.pop_front();
          if ((e.chk_res && result_o !== e.res) || flags_o !== e.flags || wb_en_o !== e.wb ||
              rd_addr_o !== e.rd || branch_en_o !== e.br) begin
            errors++;
            $display("FAIL %s: got res=%h flags=%b wb=%b rd=%h br=%b, expected res=%h flags=%b wb=%b rd=%h br=%b",
                     e.name, result_o, flags_o, wb_en_o, rd_addr_o, branch_en_o,
                     e.res, e.flags, e.wb, e.rd, e.br);
          end
        end
      end
    end
  end

  task automatic drive(input string name, input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic immf, input logic wb,
                       input logic [3:0] rd, input logic [2:0] cc, input logic [15:0] pc,
                       input bit push, input logic [31:0] eres, input logic [3:0] eflags,
                       input logic ewb, input logic ebr, input bit chk_res);
    exp_t e;
    v_i         = 1'b1;
    op_i        = op;
    rd_value_i  = a;
    immf_i      = immf;
    rs_value_i  = immf ? 32'hDEAD_BEEF : b;
    imm_value_i = immf ? b : 32'hCAFE_F00D;
    wb_i        = wb;
    rd_addr_i   = rd;
    cc_i        = cc;
    pc_value_i  = pc;
    if (push) begin
      e.name = name; e.res = eres; e.flags = eflags; e.wb = ewb;
      e.rd = rd; e.br = ebr; e.chk_res = chk_res;
      exp_q.push_back(e);
    end
  endtask

  // Wait (bounded) until stall_o is low, then let the accepting edge pass.
  task automatic wait_accept(output int waited);
    waited = 0;
    #1;
    while (stall_o === 1'b1 && waited < 100) begin
      @(negedge clk);
      #1;
      waited++;
    end
    if (stall_o !== 1'b0) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: stall_o=%b after %0d cycles, expected 0", stall_o, waited);
    end
    @(posedge clk);
  endtask

  task automatic issue(input string name, input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic immf, input logic wb,
                       input logic [3:0] rd, input logic [2:0] cc, input logic [15:0] pc,
                       input bit push, input logic [31:0] eres, input logic [3:0] eflags,
                       input logic ewb, input logic ebr, input bit chk_res, output int waited);
    @(negedge clk);
    drive(name, op, a, b, immf, wb, rd, cc, pc, push, eres, eflags, ewb, ebr, chk_res);
    wait_accept(waited);
  endtask

  int w;

  initial begin
    rst = 1'b1; stall_i = 1'b0;
    drive("in_reset", OP_ADD, 32'd1, 32'd1, 1'b0, 1'b1, 4'd1, 3'd0, 16'd0,
          1'b0, 32'd0, 4'd0, 1'b0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    #1;
    check("rst_stall_o", stall_o, 1'b0);
    check("rst_outputs", {v_o, wb_en_o, branch_en_o, rd_addr_o, flags_o, result_o}, 64'd0);
    @(negedge clk);
    rst = 1'b0; v_i = 1'b0;

    // ADD signed overflow, then SUB to zero, then taken BR on Z.
    issue("add_ovf", OP_ADD, 32'h7FFF_FFFF, 32'd1, 1'b0, 1'b1, 4'd3, 3'd0, 16'd0,
          1'b1, 32'h8000_0000, 4'b0011, 1'b1, 1'b0, 1'b1, w);
    issue("sub_zero", OP_SUB, 32'd5, 32'd5, 1'b1, 1'b1, 4'd1, 3'd0, 16'd0,
          1'b1, 32'd0, 4'b1000, 1'b1, 1'b0, 1'b1, w);
    issue("br_z_taken", OP_BR, 32'd0, 32'h10, 1'b1, 1'b1, 4'd0, 3'd1, 16'h0100,
          1'b1, 32'h0000_0110, 4'b1000, 1'b0, 1'b1, 1'b1, w);
    issue("add_squashed", OP_ADD, 32'd1, 32'd1, 1'b0, 1'b1, 4'd4, 3'd0, 16'd0,
          1'b0, 32'd0, 4'd0, 1'b0, 1'b0, 1'b0, w);
    @(negedge clk);
    v_i = 1'b0;
    #1;
    check("squash_v_o", v_o, 1'b0);

    issue("and", OP_AND, 32'hF0F0_00FF, 32'h0FF0_0F0F, 1'b0, 1'b1, 4'd2, 3'd0, 16'd0,
          1'b1, 32'h00F0_000F, 4'b0100, 1'b1, 1'b0, 1'b1, w);
    issue("or_neg", OP_OR, 32'h8000_0000, 32'd1, 1'b0, 1'b1, 4'd5, 3'd0, 16'd0,
          1'b1, 32'h8000_0001, 4'b0010, 1'b1, 1'b0, 1'b1, w);
    issue("xor_zero", OP_XOR, 32'h1234_5678, 32'h1234_5678, 1'b0, 1'b0, 4'd6, 3'd0, 16'd0,
          1'b1, 32'd0, 4'b1000, 1'b0, 1'b0, 1'b1, w);
    issue("br_nz_not_taken", OP_BR, 32'd0, 32'd4, 1'b0, 1'b1, 4'd8, 3'd2, 16'h0200,
          1'b1, 32'h0000_0204, 4'b1000, 1'b0, 1'b0, 1'b1, w);
    issue("sub_ovf", OP_SUB, 32'h8000_0000, 32'd1, 1'b0, 1'b1, 4'd9, 3'd0, 16'd0,
          1'b1, 32'h7FFF_FFFF, 4'b0101, 1'b1, 1'b0, 1'b1, w);
    issue("br_v_taken", OP_BR, 32'd0, 32'h20, 1'b1, 1'b0, 4'd10, 3'd5, 16'h0FF0,
          1'b1, 32'h0000_1010, 4'b0101, 1'b0, 1'b1, 1'b1, w);
    issue("xor_squashed", OP_XOR, 32'hFFFF_FFFF, 32'd0, 1'b0, 1'b1, 4'd11, 3'd0, 16'd0,
          1'b0, 32'd0, 4'd0, 1'b0, 1'b0, 1'b0, w);
    issue("nop_op12", OP_12, 32'd7, 32'd7, 1'b0, 1'b1, 4'd12, 3'd0, 16'd0,
          1'b1, 32'd0, 4'b0101, 1'b0, 1'b0, 1'b0, w);
`ifdef EX_UNIT_MUL_EN
    issue("mul", OP_8, 32'h0000_FFFF, 32'h0001_0001, 1'b0, 1'b1, 4'd13, 3'd0, 16'd0,
          1'b1, 32'hFFFF_FFFF, 4'b0010, 1'b1, 1'b0, 1'b1, w);
    issue("shl", OP_SHL, 32'd1, 32'd4, 1'b0, 1'b1, 4'd14, 3'd0, 16'd0,
          1'b1, 32'h10, 4'b0100, 1'b1, 1'b0, 1'b1, w);
    check("mul_iter_cycles", w, 32);
`else
    issue("nop_op8", OP_8, 32'h0000_FFFF, 32'h0001_0001, 1'b0, 1'b1, 4'd13, 3'd0, 16'd0,
          1'b1, 32'd0, 4'b0101, 1'b0, 1'b0, 1'b0, w);
    issue("shl", OP_SHL, 32'd1, 32'd4, 1'b0, 1'b1, 4'd14, 3'd0, 16'd0,
          1'b1, 32'h10, 4'b0100, 1'b1, 1'b0, 1'b1, w);
    check("op8_no_iter", w, 0);
`endif
    issue("add_after_shl", OP_ADD, 32'd2, 32'd3, 1'b0, 1'b1, 4'd15, 3'd0, 16'd0,
          1'b1, 32'd5, 4'b0100, 1'b1, 1'b0, 1'b1, w);
    check("shl_stall_cycles", w, 4);
    issue("shr_zero_amt", OP_SHR, 32'h8000_0000, 32'd0, 1'b0, 1'b1, 4'd1, 3'd0, 16'd0,
          1'b1, 32'h8000_0000, 4'b0010, 1'b1, 1'b0, 1'b1, w);
    issue("shr4", OP_SHR, 32'hF000_0000, 32'h24, 1'b1, 1'b1, 4'd2, 3'd0, 16'd0,
          1'b1, 32'h0F00_0000, 4'b0100, 1'b1, 1'b0, 1'b1, w);
    check("shr0_no_stall", w, 0);
    issue("add_hold", OP_ADD, 32'd1, 32'd1, 1'b0, 1'b1, 4'd3, 3'd0, 16'd0,
          1'b1, 32'd2, 4'b0100, 1'b1, 1'b0, 1'b1, w);
    check("shr4_stall_cycles", w, 4);

    // Downstream stall for 3 cycles with the next instruction waiting.
    @(negedge clk);
    stall_i = 1'b1;
    drive("or_after_stall", OP_OR, 32'h0000_00F0, 32'h0F, 1'b1, 1'b1, 4'd7, 3'd0, 16'd0,
          1'b1, 32'h0000_00FF, 4'b0100, 1'b1, 1'b0, 1'b1);
    for (int k = 0; k < 3; k++) begin
      #1;
      check($sformatf("hold_cycle%0d", k), {stall_o, v_o, flags_o, result_o},
            {1'b1, 1'b1, 4'b0100, 32'd2});
      @(negedge clk);
    end
    stall_i = 1'b0;
    wait_accept(w);
    check("accept_after_stall", w, 0);

    // Reset in the middle of a 7-bit SHR.
    issue("shr7_reset", OP_SHR, 32'h0000_00FF, 32'd7, 1'b0, 1'b1, 4'd9, 3'd0, 16'd0,
          1'b0, 32'd0, 4'd0, 1'b0, 1'b0, 1'b0, w);
    @(negedge clk);
    v_i = 1'b0;
    @(negedge clk);
    #1;
    check("iter_stall_o", stall_o, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    drive("add_in_reset", OP_ADD, 32'd1, 32'd1, 1'b0, 1'b1, 4'd1, 3'd0, 16'd0,
          1'b0, 32'd0, 4'd0, 1'b0, 1'b0, 1'b0);
    #1;
    check("rst_mid_stall_o", stall_o, 1'b0);
    @(negedge clk);
    #1;
    check("rst_mid_outputs", {v_o, wb_en_o, branch_en_o, rd_addr_o, flags_o, result_o}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    v_i = 1'b0;
    #1;
    check("post_rst_idle", {stall_o, v_o}, 2'b00);

    issue("add_after_rst", OP_ADD, 32'd3, 32'hFFFF_FFFD, 1'b0, 1'b1, 4'd4, 3'd0, 16'd0,
          1'b1, 32'd0, 4'b1000, 1'b1, 1'b0, 1'b1, w);
    check("no_iter_after_rst", w, 0);
    @(negedge clk);
    v_i = 1'b0;
    repeat (2) @(negedge clk);
    #3;
    check("drain_v_o", v_o, 1'b0);
    check("queue_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
